// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RV32IM pipeline.
// It takes the operands held in the ID/EX register and produces the writeback
// value and the memory-access fields for the EX/MEM register.
// RV32I ALU ops and the four multiplies are single-cycle combinational.
// DIV/DIVU/REM/REMU use an iterative restoring divider that produces one
// quotient bit per cycle. While it runs, stallreq_o is held high.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   stall[5:0]          pipeline stall vector; bit 4 holds EX/MEM
//   opcode_i, func3_i,  decoded instruction fields (opcode 0 = bubble)
//   func7_i
//   data1_i, data2_i    operands (rs1/PC, rs2/immediate)
//   ls_offset_i         load/store byte offset
//   wd_i, wreg_i        destination register and writeback enable
//   wd_o, wreg_o        destination passthrough
//   wdata_o             result
//   mem_op_o, mem_func3_o  opcode/func3 passthrough for MEM
//   mem_addr_o          effective address for LOAD/STORE, else 0
//   mem_sdata_o         store data for STORE, else 0
//   stallreq_o          EX needs the upstream stages frozen
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      stall,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      func3_i,
  input  logic [6:0]      func7_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic [XLEN-1:0] ls_offset_i,
  input  logic [4:0]      wd_i,
  input  logic            wreg_i,
  output logic [4:0]      wd_o,
  output logic            wreg_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [6:0]      mem_op_o,
  output logic [2:0]      mem_func3_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_sdata_o,
  output logic            stallreq_o
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

  // ---------------- decode ----------------
  logic is_m, is_div, alt;
  assign is_m   = (opcode_i == OPC_OP) && (func7_i == F7_MULDIV);
  assign is_div = is_m && func3_i[2];
  assign alt    = (func7_i == F7_ALT);

  // ---------------- base ALU ----------------
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] d1s, d2s;
  logic [XLEN-1:0]        alu_res;
  assign shamt = data2_i[SHW-1:0];
  assign d1s   = data1_i;
  assign d2s   = data2_i;

  always_comb begin
    alu_res = '0;
    case (func3_i)
      3'b000: alu_res = (opcode_i == OPC_OP && alt) ? data1_i - data2_i
                                                    : data1_i + data2_i;
      3'b001: alu_res = data1_i << shamt;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, d1s < d2s};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, data1_i < data2_i};
      3'b100: alu_res = data1_i ^ data2_i;
      3'b101: alu_res = alt ? XLEN'(d1s >>> shamt) : data1_i >> shamt;
      3'b110: alu_res = data1_i | data2_i;
      3'b111: alu_res = data1_i & data2_i;
      default: alu_res = '0;
    endcase
  end

  // ---------------- multiplier ----------------
  // One signed (XLEN+1)x(XLEN+1) product covers all four variants: each
  // operand gets an extension bit that is its sign for signed forms, else 0.
  logic                     mul_a_sgn, mul_b_sgn;
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN+1:0] mul_p;
  logic [XLEN-1:0]          mul_res;
  assign mul_a_sgn = (func3_i[1:0] == 2'b01) || (func3_i[1:0] == 2'b10);
  assign mul_b_sgn = (func3_i[1:0] == 2'b01);
  assign mul_a     = {mul_a_sgn & data1_i[XLEN-1], data1_i};
  assign mul_b     = {mul_b_sgn & data2_i[XLEN-1], data2_i};
  assign mul_p     = mul_a * mul_b;
  assign mul_res   = (func3_i[1:0] == 2'b00) ? mul_p[XLEN-1:0]
                                             : mul_p[2*XLEN-1:XLEN];

  // ---------------- divider ----------------
  logic            div_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  assign div_sgn  = ~func3_i[0];
  assign a_neg    = div_sgn & data1_i[XLEN-1];
  assign b_neg    = div_sgn & data2_i[XLEN-1];
  assign a_mag    = a_neg ? (~data1_i + 1'b1) : data1_i;
  assign b_mag    = b_neg ? (~data2_i + 1'b1) : data2_i;
  assign div_zero = (data2_i == '0);
  assign div_ovf  = div_sgn && (data1_i == SMIN) && (data2_i == '1);

  div_state_e      state_q, state_d;
  logic [XLEN-1:0] dvd_q, dvd_d, dsr_q, dsr_d, quot_q, quot_d, rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d, isrem_q, isrem_d;
  logic            div_stall, div_vld;
  logic [XLEN-1:0] div_res;

  // Restoring step: shift the next dividend bit into the partial remainder
  // and try to subtract the divisor. One extra bit catches the borrow.
  logic [XLEN:0] sh, diff;
  assign sh   = {rem_q, dvd_q[XLEN-1]};
  assign diff = sh - {1'b0, dsr_q};

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    isrem_d   = isrem_q;
    div_stall = 1'b0;
    div_vld   = 1'b0;
    div_res   = '0;
    case (state_q)
      S_IDLE: if (is_div) begin
        if (div_zero) begin
          div_vld = 1'b1;
          div_res = func3_i[1] ? data1_i : '1;
        end else if (div_ovf) begin
          div_vld = 1'b1;
          div_res = func3_i[1] ? '0 : SMIN;
        end else begin
          div_stall = 1'b1;
          dvd_d     = a_mag;
          dsr_d     = b_mag;
          quot_d    = '0;
          rem_d     = '0;
          cnt_d     = '0;
          qneg_d    = a_neg ^ b_neg;
          rneg_d    = a_neg;
          isrem_d   = func3_i[1];
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        div_stall = 1'b1;
        dvd_d     = {dvd_q[XLEN-2:0], 1'b0};
        rem_d     = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
        quot_d    = {quot_q[XLEN-2:0], ~diff[XLEN]};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = S_DONE;
      end
      S_DONE: begin
        div_vld = 1'b1;
        if (isrem_q) div_res = rneg_q ? (~rem_q + 1'b1) : rem_q;
        else         div_res = qneg_q ? (~quot_q + 1'b1) : quot_q;
        // Leave only once EX/MEM is free to capture the result.
        if (!stall[4]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      isrem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      isrem_q <= isrem_d;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    mem_op_o    = '0;
    mem_func3_o = '0;
    mem_addr_o  = '0;
    mem_sdata_o = '0;
    stallreq_o  = 1'b0;
    if (!rst) begin
      wd_o        = wd_i;
      wreg_o      = wreg_i;
      mem_op_o    = opcode_i;
      mem_func3_o = func3_i;
      stallreq_o  = div_stall;
      if (opcode_i == OPC_LOAD || opcode_i == OPC_STORE)
        mem_addr_o = data1_i + ls_offset_i;
      if (opcode_i == OPC_STORE)
        mem_sdata_o = data2_i;
      case (opcode_i)
        OPC_OP: begin
          if (is_m)
            wdata_o = func3_i[2] ? (div_vld ? div_res : '0) : mul_res;
          else if (func7_i == F7_BASE || func7_i == F7_ALT)
            wdata_o = alu_res;
        end
        OPC_OPIMM: wdata_o = alu_res;
        OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: wdata_o = data1_i + data2_i;
        default: wdata_o = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{stall[5], stall[3:0], mul_p[2*XLEN+1:2*XLEN]};

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage. A behavioural model computes every result
// from the instruction's meaning (plain integer arithmetic). It tracks a
// divide only as "cycles since it appeared", and a negedge process compares
// all outputs every cycle. A directed sequence adds literal checks.
module tb_ex_stage;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111,
                         AUIPC = 7'b0010111, JAL = 7'b1101111, LOAD = 7'b0000011,
                         STORE = 7'b0100011, BR = 7'b1100011;

  logic        clk = 1'b0, rst;
  logic [5:0]  stall;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [31:0] data1, data2, ls_offset;
  logic [4:0]  wd;
  logic        wreg;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq;
  logic [31:0] wdata, mem_addr, mem_sdata;
  logic [6:0]  mem_op;
  logic [2:0]  mem_func3;

  int checks = 0, errors = 0;
  int age = -1;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .opcode_i(opcode), .func3_i(func3),
    .func7_i(func7), .data1_i(data1), .data2_i(data2), .ls_offset_i(ls_offset),
    .wd_i(wd), .wreg_i(wreg), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata),
    .mem_op_o(mem_op), .mem_func3_o(mem_func3), .mem_addr_o(mem_addr),
    .mem_sdata_o(mem_sdata), .stallreq_o(stallreq));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] div_ref(input logic [2:0] f3, input logic [31:0] a, b);
    longint x, y, q, r;
    if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin x = longint'($signed(a)); y = longint'($signed(b)); end
    else        begin x = longint'({32'h0, a}); y = longint'({32'h0, b}); end
    q = x / y;
    r = x % y;
    return f3[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic logic [31:0] ref_res(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a, b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic sub, sra;
    sa = longint'($signed(a)); sb = longint'($signed(b)); ub = longint'({32'h0, b});
    if (op == OP && f7 == 7'h01) begin
      case (f3)
        3'd0: begin p = sa * sb; return p[31:0]; end
        3'd1: begin p = sa * sb; return p[63:32]; end
        3'd2: begin p = sa * ub; return p[63:32]; end
        3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
        default: return div_ref(f3, a, b);
      endcase
    end
    if (op == OP && f7 != 7'h00 && f7 != 7'h20) return 32'h0;
    if (op == OP || op == OPI) begin
      sub = (op == OP) && (f7 == 7'h20);
      sra = (f7 == 7'h20);
      case (f3)
        3'd0: return sub ? a - b : a + b;
        3'd1: return a << b[4:0];
        3'd2: return (sa < sb) ? 32'd1 : 32'd0;
        3'd3: return (a < b) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: begin p = sa >>> b[4:0]; return sra ? p[31:0] : a >> b[4:0]; end
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    if (op == LUI || op == AUIPC || op == JAL || op == 7'b1100111) return a + b;
    return 32'h0;
  endfunction

  // A divide that has to iterate (not by zero, not signed overflow).
  function automatic logic long_div(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [31:0] a, b);
    if (!(op == OP && f7 == 7'h01 && f3[2])) return 1'b0;
    if (b == 0) return 1'b0;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b0;
    return 1'b1;
  endfunction

  // Compare every cycle. A long divide stalls for its first 33 cycles, then
  // shows its result until a cycle with stall[4] low lets it retire.
  always @(negedge clk) begin : compare_p
    logic lng, es;
    lng = !rst && long_div(opcode, func3, func7, data1, data2);
    if (lng && age < 0) age = 0;
    if (rst) begin
      chk("m_rst_wdata", wdata, 0);
      chk("m_rst_stallreq", {31'h0, stallreq}, 0);
      chk("m_rst_wd", {27'h0, wd_o}, 0);
      chk("m_rst_wreg", {31'h0, wreg_o}, 0);
      chk("m_rst_memop", {25'h0, mem_op}, 0);
      chk("m_rst_memf3", {29'h0, mem_func3}, 0);
      chk("m_rst_addr", mem_addr, 0);
      chk("m_rst_sdata", mem_sdata, 0);
    end else begin
      es = lng && (age <= 32);
      chk("m_stallreq", {31'h0, stallreq}, {31'h0, es});
      if (!es) chk("m_wdata", wdata, ref_res(opcode, func3, func7, data1, data2));
      chk("m_wd", {27'h0, wd_o}, {27'h0, wd});
      chk("m_wreg", {31'h0, wreg_o}, {31'h0, wreg});
      chk("m_memop", {25'h0, mem_op}, {25'h0, opcode});
      chk("m_memf3", {29'h0, mem_func3}, {29'h0, func3});
      chk("m_addr", mem_addr, (opcode == LOAD || opcode == STORE) ? data1 + ls_offset : 0);
      chk("m_sdata", mem_sdata, (opcode == STORE) ? data2 : 0);
    end
    if (rst || !lng) age = -1;
    else if (age >= 33 && !stall[4]) age = -1;
    else age++;
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, b);
    opcode = op; func3 = f3; func7 = f7; data1 = a; data2 = b;
    wd = a[4:0] ^ 5'h15; wreg = (op != 7'h0);
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  // Count stall cycles from the cycle the divide appears, then check the result.
  task automatic run_div(input string name, input int exp_cyc, input logic [31:0] exp);
    int n = 0;
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stallreq) n++; else done = 1;
    end
    chk({name, "_stall_cycles"}, n, exp_cyc);
    chk(name, wdata, exp);
  endtask

  logic [6:0]  t_op [14] = '{OP, OP, OP, OP, OP, OP, OP, OPI, LUI, AUIPC, JAL, STORE, BR, OP};
  logic [2:0]  t_f3 [14] = '{1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 2, 0, 2};
  logic [6:0]  t_f7 [14] = '{0, 0, 0, 0, 0, 0, 0, 7'h20, 0, 0, 0, 0, 0, 1};
  logic [31:0] t_a  [14] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'h8000_0000,
                             32'h0F00_0000, 32'hFF00_FF00, 10, 0, 32'h100, 32'h200,
                             32'h2000, 7, 32'hFFFF_FFFF};
  logic [31:0] t_b  [14] = '{35, 1, 1, 32'h0FF0_0FF0, 4, 32'h0000_00F0, 32'h0F0F_0F0F,
                             32'hFFFF_FFF6, 32'h1234_5000, 32'h10, 4, 32'hDEAD, 9, 2};

  initial begin
    rst = 1; stall = 0; ls_offset = 32'h10;
    drive(OP, 0, 0, 5, 32'hFFFF_FFFD);
    @(negedge clk);
    chk("rst_wdata", wdata, 0);
    chk("rst_stallreq", {31'h0, stallreq}, 0);
    @(posedge clk); next_cycle(); rst = 0;

    @(negedge clk);
    chk("add", wdata, 32'h2);
    chk("add_stallreq", {31'h0, stallreq}, 0);
    next_cycle(); drive(OP, 0, 7'h20, 3, 5);
    @(negedge clk); chk("sub", wdata, 32'hFFFF_FFFE);
    next_cycle(); drive(OPI, 5, 7'h20, 32'h8000_0000, 4);
    @(negedge clk); chk("srai", wdata, 32'hF800_0000);
    next_cycle(); drive(OP, 1, 1, 32'h8000_0000, 32'h8000_0000);
    @(negedge clk);
    chk("mulh", wdata, 32'h4000_0000);
    chk("mulh_stallreq", {31'h0, stallreq}, 0);
    next_cycle(); drive(OP, 3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("mulhu", wdata, 32'hFFFF_FFFE);
    chk("mulhu_stallreq", {31'h0, stallreq}, 0);

    for (int i = 0; i < 14; i++) begin
      next_cycle(); drive(t_op[i], t_f3[i], t_f7[i], t_a[i], t_b[i]);
      @(negedge clk);
    end

    next_cycle(); drive(OP, 4, 1, 100, 32'hFFFF_FFF9);
    run_div("div", 33, 32'hFFFF_FFF2);
    next_cycle(); drive(OP, 6, 1, 100, 32'hFFFF_FFF9);
    run_div("rem", 33, 32'h2);
    next_cycle(); drive(OP, 5, 1, 32'h1234, 0);
    run_div("divu_by0", 0, 32'hFFFF_FFFF);
    next_cycle(); drive(OP, 6, 1, 32'h1234, 0);
    run_div("rem_by0", 0, 32'h1234);
    next_cycle(); drive(OP, 4, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("div_ovf", 0, 32'h8000_0000);
    next_cycle(); drive(OP, 6, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("rem_ovf", 0, 32'h0);
    next_cycle(); drive(OP, 7, 1, 32'hFFFF_FFFF, 10);
    run_div("remu", 33, 32'h5);

    // Result held in DONE while EX/MEM is stalled.
    next_cycle(); stall = 6'b010000; drive(OP, 4, 1, 32'hFFFF_FF9C, 7);
    run_div("div_held", 33, 32'hFFFF_FFF2);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("held_wdata", wdata, 32'hFFFF_FFF2);
      chk("held_stallreq", {31'h0, stallreq}, 0);
    end
    next_cycle(); stall = 0;
    next_cycle(); drive(OP, 5, 1, 9, 2);
    run_div("divu_after_hold", 33, 32'h4);

    // Reset in the middle of an iteration.
    next_cycle(); drive(OP, 4, 1, 100, 32'hFFFF_FFF9);
    repeat (11) @(posedge clk);
    #1; rst = 1; drive(7'h0, 0, 0, 0, 0);
    @(negedge clk);
    chk("midrst_stallreq", {31'h0, stallreq}, 0);
    chk("midrst_wdata", wdata, 0);
    next_cycle(); rst = 0;
    @(negedge clk); chk("postrst_stallreq", {31'h0, stallreq}, 0);
    next_cycle(); ls_offset = 32'hFFFF_FFFC; drive(LOAD, 2, 0, 32'h1000, 0);
    @(negedge clk);
    chk("load_addr", mem_addr, 32'hFFC);
    chk("load_wdata", wdata, 0);
    next_cycle(); ls_offset = 32'h10; drive(OP, 5, 1, 9, 2);
    run_div("divu_postrst", 33, 32'h4);

    next_cycle(); drive(7'h0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32IM pipeline.
- Consumes the decoded operands registered by the ID/EX pipeline register and produces the writeback value and memory-access fields for the EX/MEM register.
- RV32I ALU ops and RV32M multiplies are single-cycle combinational.
- DIV/DIVU/REM/REMU run on an iterative radix-2 divider. While it runs, the stage raises stallreq_o so the stall controller freezes upstream stages.

Parameters:
- XLEN, 32, datapath width; the divider iterates XLEN times.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  6  pipeline stall vector; bit 4 = EX/MEM hold
- opcode_i  in  7  instruction opcode; 0000000 = bubble
- func3_i  in  3  func3
- func7_i  in  7  func7
- data1_i  in  XLEN  operand 1 (rs1 value, or PC for AUIPC/JAL)
- data2_i  in  XLEN  operand 2 (rs2 value or immediate; 4 for JAL/JALR; 0 for LUI)
- ls_offset_i  in  XLEN  load/store byte offset
- wd_i  in  5  destination register
- wreg_i  in  1  writeback enable
- wd_o  out  5  destination register passthrough
- wreg_o  out  1  writeback enable passthrough
- wdata_o  out  XLEN  result
- mem_op_o  out  7  opcode passthrough for MEM
- mem_func3_o  out  3  width/sign for MEM
- mem_addr_o  out  XLEN  data1_i + ls_offset_i (LOAD/STORE), else 0
- mem_sdata_o  out  XLEN  data2_i for STORE, else 0
- stallreq_o  out  1  EX requests pipeline stall

Behaviour:
- rst high: all outputs 0; divider FSM returns to IDLE and clears its operand, quotient, remainder and counter registers. This also applies mid-division.
- Outputs are combinational from the inputs and divider state. There are no output registers; EX/MEM does the latching.

Opcode decode:
- OP (0110011) with func7 = 0000000 or 0100000: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- OP-IMM (0010011): same ops with data2_i as the immediate.
- Shift amount = operand2[4:0].
- SRAI is selected by func7 = 0100000.
- LUI, AUIPC, JAL, JALR: wdata = data1_i + data2_i.
- LOAD, STORE, BRANCH, bubble: wdata = 0.

M extension (OP with func7 = 0000001):
- MUL: low 32 bits of the 64-bit product.
- MULH: signed × signed, high 32 bits.
- MULHSU: signed × unsigned, high 32 bits.
- MULHU: unsigned × unsigned, high 32 bits.
- All four are combinational, with zero stall.

Divider FSM states: IDLE, BUSY, DONE.
- IDLE, division op present:
  - Divisor = 0: quotient = all-ones, remainder = dividend. Combinational, no stall.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. Combinational, no stall.
  - Otherwise: stallreq_o = 1; latch operand magnitudes and result signs; counter = 0; → BUSY.
- BUSY:
  - stallreq_o = 1 every cycle.
  - One restoring shift-subtract step per cycle.
  - After XLEN steps → DONE.
- DONE:
  - stallreq_o = 0.
  - wdata_o = sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU).
  - Quotient sign = sign(a) XOR sign(b); remainder takes the dividend's sign.
  - Stay in DONE while stall[4] = 1; → IDLE when stall[4] = 0, because EX/MEM captures the result that cycle.
- Latency: a division present in cycle 0 holds stallreq_o high for cycles 0..XLEN (33 cycles) and delivers its result in cycle XLEN+1.
- Operand stability: inputs are held stable by ID/EX during stallreq_o. The divider uses its latched operands and does not re-sample the inputs in BUSY.
- Back-to-back divides: the second divide enters IDLE on the cycle after DONE exits and starts normally.
- Non-divide ops present while the FSM is IDLE never touch FSM state.

Test Plan:
- ADD: data1 = 5, data2 = 0xFFFFFFFD → wdata 2, stallreq 0. SUB (func7 0100000): data1 = 3, data2 = 5 → 0xFFFFFFFE. SRAI: 0x80000000 >> 4 → 0xF8000000.
- DIV: data1 = 100, data2 = −7 (0xFFFFFFF9) → stallreq high exactly 33 cycles, then wdata 0xFFFFFFF2 (−14). REM on the same operands → 2.
- DIVU by 0 with data1 = 0x1234 → wdata 0xFFFFFFFF same cycle, stallreq never asserted. REM by 0 → 0x1234. DIV 0x80000000 / −1 → 0x80000000, no stall.
- MULH: 0x80000000 × 0x80000000 → 0x40000000. MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. Both with stallreq 0.
- DIV finishing with stall[4] = 1 for 3 cycles → FSM stays in DONE with wdata stable and stallreq 0. It returns to IDLE the cycle stall[4] drops, and a following DIVU 9/2 → 4 after 33 stall cycles.
- rst asserted at BUSY count 10 → next cycle FSM IDLE, stallreq 0, all outputs 0. LOAD with data1 = 0x1000, ls_offset = 0xFFFFFFFC → mem_addr 0xFFC, wdata 0.
